// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared state, opcode and mux-select definitions for main and ALU control
// MC_ILLEGAL_TRAP_EN adds the parked TRAP state to the state enum.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_ADDR,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_WB_ALU,
        ST_WB_MEM,
        ST_BRANCH,
        ST_JAL
`ifdef MC_ILLEGAL_TRAP_EN
        , ST_TRAP
`endif
    } state_e;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_FUNC = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_ADD  = 2'b10;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_RS1    = 2'b01;
    localparam logic [1:0] SRCA_OLD_PC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MDR = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam logic [2:0] F3_SHIFT_RIGHT = 3'b101;

    // For immediate ops IR[30] is immediate data except on right shifts (SRLI/SRAI).
    function automatic logic [3:0] alu_instr(input logic funct7_5, input logic [2:0] funct3,
                                             input logic is_imm);
        return {(is_imm && funct3 != F3_SHIFT_RIGHT) ? 1'b0 : funct7_5, funct3};
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - RV32I multicycle main control FSM with retired-instruction counter
// MC_ILLEGAL_TRAP_EN parks illegal opcodes in a sticky TRAP state; otherwise they retire as NOPs.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [6:0]       OPCODE,
    input  logic [2:0]       FUNCT3,
    input  logic             FUNCT7_5,
    input  logic             MEM_READY,
    input  logic             ZERO,
    output logic [1:0]       ALUOP,
    output logic [3:0]       INSTRUCCION,
    output logic             PC_WRITE,
    output logic             PC_SRC,
    output logic             IR_WRITE,
    output logic             MEM_READ,
    output logic             MEM_WRITE,
    output logic             IORD,
    output logic             REG_WRITE,
    output logic [1:0]       MEM_TO_REG,
    output logic [1:0]       ALUSRC_A,
    output logic [1:0]       ALUSRC_B,
    output logic [CNT_W-1:0] RETIRED,
    output logic             TRAP
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // retire marks the exit edge of an instruction's last state.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_FETCH:  if (MEM_READY) state_d = ST_DECODE;
            ST_DECODE: begin
                case (OPCODE)
                    OP_R_TYPE:         state_d = ST_EXEC_R;
                    OP_I_ALU:          state_d = ST_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = ST_ADDR;
                    OP_BRANCH:         state_d = ST_BRANCH;
                    OP_JAL:            state_d = ST_JAL;
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        state_d = ST_TRAP;
`else
                        state_d = ST_FETCH;
                        retire  = 1'b1;
`endif
                    end
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: state_d = ST_WB_ALU;
            ST_ADDR:   state_d = (OPCODE == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: if (MEM_READY) state_d = ST_WB_MEM;
            ST_MEM_WR: begin
                if (MEM_READY) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JAL: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            ST_TRAP:   state_d = ST_TRAP;
`endif
            default:   state_d = ST_FETCH;
        endcase
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_comb begin
        ALUOP       = ALUOP_FUNC;
        INSTRUCCION = 4'b0000;
        PC_WRITE    = 1'b0;
        PC_SRC      = 1'b0;
        IR_WRITE    = 1'b0;
        MEM_READ    = 1'b0;
        MEM_WRITE   = 1'b0;
        IORD        = 1'b0;
        REG_WRITE   = 1'b0;
        MEM_TO_REG  = WB_SEL_ALU;
        ALUSRC_A    = SRCA_PC;
        ALUSRC_B    = SRCB_RS2;
        TRAP        = 1'b0;
        case (state_q)
            ST_FETCH: begin
                MEM_READ = 1'b1;
                ALUSRC_B = SRCB_FOUR;
                ALUOP    = ALUOP_ADD;
                IR_WRITE = MEM_READY;
                PC_WRITE = MEM_READY;
            end
            ST_DECODE: begin
                ALUSRC_A = SRCA_OLD_PC;
                ALUSRC_B = SRCB_IMM;
                ALUOP    = ALUOP_ADD;
            end
            ST_EXEC_R: begin
                ALUSRC_A    = SRCA_RS1;
                ALUSRC_B    = SRCB_RS2;
                ALUOP       = ALUOP_FUNC;
                INSTRUCCION = alu_instr(FUNCT7_5, FUNCT3, 1'b0);
            end
            ST_EXEC_I: begin
                ALUSRC_B    = SRCB_IMM;
                ALUOP       = ALUOP_FUNC;
                INSTRUCCION = alu_instr(FUNCT7_5, FUNCT3, 1'b1);
            end
            ST_ADDR: begin
                ALUSRC_A = SRCA_RS1;
                ALUSRC_B = SRCB_IMM;
                ALUOP    = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                IORD     = 1'b1;
                MEM_READ = 1'b1;
            end
            ST_MEM_WR: begin
                IORD      = 1'b1;
                MEM_WRITE = 1'b1;
            end
            ST_WB_ALU: begin
                REG_WRITE  = 1'b1;
                MEM_TO_REG = WB_SEL_ALU;
            end
            ST_WB_MEM: begin
                REG_WRITE  = 1'b1;
                MEM_TO_REG = WB_SEL_MDR;
            end
            ST_BRANCH: begin
                ALUSRC_A = SRCA_RS1;
                ALUSRC_B = SRCB_RS2;
                ALUOP    = ALUOP_SUB;
                PC_WRITE = ZERO ^ FUNCT3[0];
                PC_SRC   = 1'b1;
            end
            ST_JAL: begin
                REG_WRITE  = 1'b1;
                MEM_TO_REG = WB_SEL_PC4;
                PC_WRITE   = 1'b1;
                PC_SRC     = 1'b1;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            ST_TRAP: TRAP = 1'b1;
`endif
            default: ;
        endcase
    end

    assign RETIRED = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table, corner-case and randomized checks of multicycle_control
// Follows MC_ILLEGAL_TRAP_EN when the design is built with it.
module tb_multicycle_control;

    localparam int CNT_W = 32;

    logic             CLK, RST_N;
    logic [6:0]       OPCODE;
    logic [2:0]       FUNCT3;
    logic             FUNCT7_5, MEM_READY, ZERO;
    logic [1:0]       ALUOP, MEM_TO_REG, ALUSRC_A, ALUSRC_B;
    logic [3:0]       INSTRUCCION;
    logic             PC_WRITE, PC_SRC, IR_WRITE, MEM_READ, MEM_WRITE, IORD, REG_WRITE, TRAP;
    logic [CNT_W-1:0] RETIRED;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .FUNCT3(FUNCT3), .FUNCT7_5(FUNCT7_5),
        .MEM_READY(MEM_READY), .ZERO(ZERO), .ALUOP(ALUOP), .INSTRUCCION(INSTRUCCION),
        .PC_WRITE(PC_WRITE), .PC_SRC(PC_SRC), .IR_WRITE(IR_WRITE), .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE), .IORD(IORD), .REG_WRITE(REG_WRITE), .MEM_TO_REG(MEM_TO_REG),
        .ALUSRC_A(ALUSRC_A), .ALUSRC_B(ALUSRC_B), .RETIRED(RETIRED), .TRAP(TRAP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef enum int {S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD, S_MEM_WR,
                      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_TRAP} step_e;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        int         fw;
        int         mw;
        int         lat;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl[NV];

    int               n_vec = 0, n_bad = 0;
    int               exp_retired = 0, meas_lat, cyc;
    logic [CNT_W-1:0] r0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] act_vec();
        return {12'd0, ALUOP, INSTRUCCION, PC_WRITE, PC_SRC, IR_WRITE, MEM_READ, MEM_WRITE, IORD,
                REG_WRITE, MEM_TO_REG, ALUSRC_A, ALUSRC_B, TRAP};
    endfunction

    // Reference: output values each control step must present, straight from the step rules.
    function automatic logic [31:0] exp_out(input step_e s, input logic rdy);
        logic [1:0] aluop = 2'b00, m2r = 2'b00, sa = 2'b00, sb = 2'b00;
        logic [3:0] ins = 4'b0000;
        logic pcw = 0, pcs = 0, irw = 0, mr = 0, mwr = 0, iord = 0, rw = 0, trap = 0;
        case (s)
            S_FETCH:  begin mr = 1; sb = 2'b01; aluop = 2'b10; irw = rdy; pcw = rdy; end
            S_DECODE: begin sa = 2'b10; sb = 2'b10; aluop = 2'b10; end
            S_EXEC_R: begin sa = 2'b01; ins = {FUNCT7_5, FUNCT3}; end
            S_EXEC_I: begin sb = 2'b10; ins = {(FUNCT3 == 3'd5) ? FUNCT7_5 : 1'b0, FUNCT3}; end
            S_ADDR:   begin sa = 2'b01; sb = 2'b10; aluop = 2'b10; end
            S_MEM_RD: begin iord = 1; mr = 1; end
            S_MEM_WR: begin iord = 1; mwr = 1; end
            S_WB_ALU: rw = 1;
            S_WB_MEM: begin rw = 1; m2r = 2'b01; end
            S_BRANCH: begin sa = 2'b01; aluop = 2'b01; pcw = ZERO ^ FUNCT3[0]; pcs = 1; end
            S_JAL:    begin rw = 1; m2r = 2'b10; pcw = 1; pcs = 1; end
            S_TRAP:   trap = 1;
            default:  ;
        endcase
        return {12'd0, aluop, ins, pcw, pcs, irw, mr, mwr, iord, rw, m2r, sa, sb, trap};
    endfunction

    function automatic bit trap_build();
`ifdef MC_ILLEGAL_TRAP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
    endfunction

    // Cycles from first FETCH cycle to the retire edge; -1 when the instruction never retires.
    function automatic int model_lat(input logic [6:0] op, input int fw, input int mw);
        case (op)
            7'b0110011, 7'b0010011: return 4 + fw;
            7'b0000011:             return 5 + fw + mw;
            7'b0100011:             return 4 + fw + mw;
            7'b1100011, 7'b1101111: return 3 + fw;
            default:                return trap_build() ? -1 : 2 + fw;
        endcase
    endfunction

    task automatic step(input step_e s, input int waits);
        for (int w = 0; w <= waits; w++) begin
            @(negedge CLK);
            if (s == S_FETCH || s == S_MEM_RD || s == S_MEM_WR) MEM_READY = (w == waits);
            else MEM_READY = 1'($urandom_range(0, 1));
            #1;
            if (meas_lat < 0 && RETIRED != r0) meas_lat = cyc;
            chk($sformatf("step%0d_cyc%0d", s, cyc), act_vec(), exp_out(s, MEM_READY));
            cyc++;
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        exp_retired = 0;
        chk("reset_outputs", act_vec(), exp_out(S_FETCH, MEM_READY));
        chk("reset_retired", RETIRED, 32'(exp_retired));
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw);
        bit trapped = 1'b0;
        OPCODE = op; FUNCT3 = f3; FUNCT7_5 = f7; ZERO = z;
        r0 = RETIRED; cyc = 0; meas_lat = -1;
        step(S_FETCH, fw);
        step(S_DECODE, 0);
        case (op)
            7'b0110011: begin step(S_EXEC_R, 0); step(S_WB_ALU, 0); end
            7'b0010011: begin step(S_EXEC_I, 0); step(S_WB_ALU, 0); end
            7'b0000011: begin step(S_ADDR, 0); step(S_MEM_RD, mw); step(S_WB_MEM, 0); end
            7'b0100011: begin step(S_ADDR, 0); step(S_MEM_WR, mw); end
            7'b1100011: step(S_BRANCH, 0);
            7'b1101111: step(S_JAL, 0);
            default: begin
                if (trap_build()) begin
                    trapped = 1'b1;
                    repeat (3) step(S_TRAP, 0);
                end
            end
        endcase
        if (!trapped) exp_retired++;
        @(posedge CLK);
        #1;
        if (meas_lat < 0 && RETIRED != r0) meas_lat = cyc;
        chk("retired_count", RETIRED, 32'(exp_retired));
        if (trapped) apply_reset();
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic z, input int fw, input int mw, input int lat);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.zero = z; v.fw = fw; v.mw = mw; v.lat = lat;
        return v;
    endfunction

    initial begin
        tbl[0]  = mk(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 4);   // ADD
        tbl[1]  = mk(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 4);   // SUB
        tbl[2]  = mk(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 4);   // ADDI, IR[30]=1
        tbl[3]  = mk(7'b0010011, 3'b101, 1'b1, 1'b0, 0, 0, 4);   // SRAI
        tbl[4]  = mk(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3, 8);   // LW, 3 wait cycles
        tbl[5]  = mk(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0, 4);   // SW
        tbl[6]  = mk(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 3);   // BEQ taken
        tbl[7]  = mk(7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, 3);   // BNE not taken
        tbl[8]  = mk(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 3);   // BEQ not taken
        tbl[9]  = mk(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 3);   // JAL
        tbl[10] = mk(7'b0110011, 3'b111, 1'b0, 1'b0, 2, 0, 6);   // AND, slow fetch
        tbl[11] = mk(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, trap_build() ? -1 : 2);

        RST_N = 1'b0; MEM_READY = 1'b0; OPCODE = '0; FUNCT3 = '0; FUNCT7_5 = 1'b0; ZERO = 1'b0;
        #2;
        chk("reset_outputs", act_vec(), exp_out(S_FETCH, 1'b0));
        chk("reset_retired", RETIRED, 32'd0);
        chk("reset_trap", {31'd0, TRAP}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].zero, tbl[i].fw, tbl[i].mw);
            chk($sformatf("tbl%0d_latency", i), 32'(meas_lat), 32'(tbl[i].lat));
        end

        // Reset asserted while a store waits on memory: request drops at once, no retire.
        OPCODE = 7'b0100011; FUNCT3 = 3'b010; FUNCT7_5 = 1'b0;
        r0 = RETIRED; cyc = 0; meas_lat = -1;
        step(S_FETCH, 0);
        step(S_DECODE, 0);
        step(S_ADDR, 0);
        @(negedge CLK);
        MEM_READY = 1'b0;
        #1;
        chk("store_wait", act_vec(), exp_out(S_MEM_WR, 1'b0));
        #2;
        RST_N = 1'b0;
        #1;
        exp_retired = 0;
        chk("rst_mid_mem_write", {31'd0, MEM_WRITE}, 32'd0);
        chk("rst_mid_outputs", act_vec(), exp_out(S_FETCH, 1'b0));
        chk("rst_mid_retired", RETIRED, 32'(exp_retired));
        @(negedge CLK);
        RST_N = 1'b1;
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
        chk("post_reset_latency", 32'(meas_lat), 32'd4);

        for (int i = 0; i < 150; i++) begin
            logic [6:0] op;
            logic [6:0] legal_ops[6] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                         7'b0100011, 7'b1100011, 7'b1101111};
            int sel, fw, mw;
            sel = $urandom_range(0, 7);
            op  = (sel < 6) ? legal_ops[sel] : 7'($urandom);
            fw  = $urandom_range(0, 2);
            mw  = $urandom_range(0, 3);
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), fw, mw);
            chk($sformatf("rand%0d_latency_op%b", i, op), 32'(meas_lat),
                32'(model_lat(op, fw, is_legal(op) ? mw : 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
